// File: rtl/instr_prefetch_queue_pkg.sv
// Shared processor constants used by the instruction prefetch queue.
// PQ_PC_WIDTH / PQ_INSTR_WIDTH mirror the datapath widths of the core,
// NOP_INSTR is the encoding handed to decode when no entry is valid.
package instr_prefetch_queue_pkg;

    localparam int          PQ_PC_WIDTH    = 16;
    localparam int          PQ_INSTR_WIDTH = 32;
    localparam int          PQ_DEPTH       = 4;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

endpackage

// File: rtl/instr_prefetch_queue_storage.sv
// pq_storage: DEPTH x DW register array for the prefetch queue.
// Ports:
//   clk_in    - rising-edge clock
//   wr_en_i   - write strobe for wr_addr_i
//   wr_addr_i - write slot
//   wr_data_i - {pc, instr} pair to store
//   rd_addr_i - read slot (asynchronous read)
//   rd_data_o - contents of rd_addr_i
// Contents are deliberately not reset; validity is tracked by the owner.
module pq_storage #(
    parameter int DEPTH = 4,
    parameter int DW    = 48,
    parameter int AW    = 2
) (
    input  logic          clk_in,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Single synchronous write port.
    always_ff @(posedge clk_in) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: FIFO of {pc, instr} pairs between fetch and decode.
// Ports:
//   clk_in, RST          - clock and asynchronous active-high reset
//   f_valid/f_pc/f_instr - push side from fetch, f_ready = room available
//   d_valid/d_pc/d_instr - head entry toward decode (0 / NOP when empty)
//   d_ready              - decode consumes the head this cycle
//   pc_chg               - redirect from execute; empties the queue
//   level                - current occupancy
//   ovf_err              - sticky flag: fetch pushed while full
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int PC_WIDTH    = PQ_PC_WIDTH,
    parameter int INSTR_WIDTH = PQ_INSTR_WIDTH,
    parameter int DEPTH       = PQ_DEPTH,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic                   f_valid,
    input  logic [PC_WIDTH-1:0]    f_pc,
    input  logic [INSTR_WIDTH-1:0] f_instr,
    output logic                   f_ready,
    output logic                   d_valid,
    output logic [PC_WIDTH-1:0]    d_pc,
    output logic [INSTR_WIDTH-1:0] d_instr,
    input  logic                   d_ready,
    input  logic                   pc_chg,
    output logic [CNT_W-1:0]       level,
    output logic                   ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = PC_WIDTH + INSTR_WIDTH;
    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(NOP_INSTR);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             full_s, empty_s, push_s, pop_s;
    logic [DW-1:0]    rd_data_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // f_ready looks only at registered state (pre-pop), so a full queue
    // never accepts a push even when decode pops in the same cycle.
    assign f_ready = !full_s && !RST;
    assign push_s  = f_valid && f_ready && !pc_chg;
    assign pop_s   = !empty_s && d_ready && !pc_chg;

    pq_storage #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_storage (
        .clk_in    (clk_in),
        .wr_en_i   (push_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({f_pc, f_instr}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_s)
    );

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pc_chg) begin
            // Redirect discards every entry; storage contents are left stale.
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CNT_W{1'b0}};
            ovf_d    = ovf_q;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (f_valid && full_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Decode view: head entry, or zero PC / NOP when nothing is valid.
    always_comb begin
        d_valid = !empty_s;
        if (empty_s) begin
            d_pc    = {PC_WIDTH{1'b0}};
            d_instr = NOP_WORD;
        end else begin
            d_pc    = rd_data_s[DW-1:INSTR_WIDTH];
            d_instr = rd_data_s[INSTR_WIDTH-1:0];
        end
    end

    assign level   = count_q;
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;
    import instr_prefetch_queue_pkg::*;

    localparam int PCW   = 16;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int VW    = 1 + PCW + IW + CNT_W + 1 + 1;

    logic             clk_in = 1'b0;
    logic             RST    = 1'b1;
    logic             f_valid = 1'b0;
    logic [PCW-1:0]   f_pc    = 16'h0;
    logic [IW-1:0]    f_instr = 32'h0;
    logic             f_ready;
    logic             d_valid;
    logic [PCW-1:0]   d_pc;
    logic [IW-1:0]    d_instr;
    logic             d_ready = 1'b0;
    logic             pc_chg  = 1'b0;
    logic [CNT_W-1:0] level;
    logic             ovf_err;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of stored pairs plus a sticky flag.
    logic [PCW+IW-1:0] mq[$];
    bit                movf = 1'b0;

    instr_prefetch_queue #(
        .PC_WIDTH    (PCW),
        .INSTR_WIDTH (IW),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_in  (clk_in),
        .RST     (RST),
        .f_valid (f_valid),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .f_ready (f_ready),
        .d_valid (d_valid),
        .d_pc    (d_pc),
        .d_instr (d_instr),
        .d_ready (d_ready),
        .pc_chg  (pc_chg),
        .level   (level),
        .ovf_err (ovf_err)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [VW-1:0] obs_vec();
        return {d_valid, d_pc, d_instr, level, f_ready, ovf_err};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic             v;
        logic [PCW-1:0]   p;
        logic [IW-1:0]    ins;
        logic [CNT_W-1:0] lv;
        logic             rdy;
        v   = (mq.size() > 0);
        p   = v ? mq[0][PCW+IW-1:IW] : 16'h0;
        ins = v ? mq[0][IW-1:0] : NOP_INSTR;
        lv  = CNT_W'(mq.size());
        rdy = (mq.size() < DEPTH) && !RST;
        return {v, p, ins, lv, rdy, movf};
    endfunction

    task automatic set_in(input logic v, input logic [PCW-1:0] pc,
                          input logic [IW-1:0] ins, input logic dr, input logic chg);
        f_valid = v;
        f_pc    = pc;
        f_instr = ins;
        d_ready = dr;
        pc_chg  = chg;
        #1;
    endtask

    // Advance model by one clock using the current inputs, then the DUT.
    task automatic step();
        bit full;
        bit do_push;
        bit do_pop;
        logic [PCW+IW-1:0] ent;
        full = 1'b0; do_push = 1'b0; do_pop = 1'b0;
        ent = {f_pc, f_instr};
        if (!RST) begin
            full = (mq.size() == DEPTH);
            if (pc_chg) begin
                mq.delete();
            end else begin
                if (f_valid && full) movf = 1'b1;
                do_push = f_valid && !full;
                do_pop  = d_ready && (mq.size() > 0);
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(ent);
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        movf = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        set_in(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_hold got %h exp %h", obs_vec(), exp_vec());
        end
        RST = 1'b0;
        #1;
        checks++;
        if (f_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got %b exp 1", f_ready);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 16'h200 + 16'(4*i), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        set_in(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (level !== 3'd3) begin
            errors++; $display("FAIL reset_prefill_level got %0d exp 3", level);
        end
        // Assert RST between edges: must take effect immediately.
        RST = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({d_valid, level, f_ready, d_instr} !== {1'b0, 3'd0, 1'b0, NOP_INSTR}) begin
            errors++; $display("FAIL reset_async got v=%b lvl=%0d rdy=%b ins=%h exp 0/0/0/NOP",
                               d_valid, level, f_ready, d_instr);
        end
        step();
        RST = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_after_release got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 16'h10 + 16'(4*i), 32'hA5A5_0010 + 32'(4*i), 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL fill_cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            step();
        end
        set_in(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({level, f_ready} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL fill_full got lvl=%0d rdy=%b exp 4/0", level, f_ready);
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if ({d_valid, d_pc} !== {1'b1, 16'h10 + 16'(4*i)} || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL drain_cyc%0d got pc=%h vec=%h exp pc=%h vec=%h",
                                   i, d_pc, obs_vec(), 16'h10 + 16'(4*i), exp_vec());
            end
            step();
        end
        checks++;
        if ({d_valid, d_pc, d_instr} !== {1'b0, 16'h0, NOP_INSTR}) begin
            errors++; $display("FAIL drain_empty got v=%b pc=%h ins=%h exp 0/0/NOP",
                               d_valid, d_pc, d_instr);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 16'h300 + 16'(4*i), 32'h1234_0000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        // Full, push attempt and pop together: only the pop happens.
        set_in(1'b1, 16'h3F0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        step();
        checks++;
        if ({level, ovf_err} !== {3'd3, 1'b1} || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL full_pop got lvl=%0d ovf=%b exp 3/1 (vec %h vs %h)",
                               level, ovf_err, obs_vec(), exp_vec());
        end
        set_in(1'b1, 16'h3F4, 32'hFEED_0001, 1'b0, 1'b0);
        step();
        checks++;
        if (level !== 3'd4 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL full_repush got lvl=%0d exp 4 (vec %h vs %h)",
                               level, obs_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL full_drain%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            step();
        end
    endtask

    task automatic test_streaming();
        logic [PCW-1:0] got[$];
        for (int i = 0; i < 21; i++) begin
            if (i < 20) set_in(1'b1, 16'h100 + 16'(4*i), $urandom, 1'b1, 1'b0);
            else        set_in(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || (i >= 1 && level !== 3'd1)) begin
                errors++; $display("FAIL stream_cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            if (d_valid) got.push_back(d_pc);
            step();
        end
        checks++;
        if (got.size() != 20) begin
            errors++; $display("FAIL stream_count got %0d exp 20", got.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                if (got[i] !== 16'h100 + 16'(4*i)) begin
                    errors++; $display("FAIL stream_order idx %0d got %h exp %h",
                                       i, got[i], 16'h100 + 16'(4*i));
                    break;
                end
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 16'h20 + 16'(4*i), 32'h0F0F_0000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        set_in(1'b1, 16'h40, 32'h4040_4040, 1'b1, 1'b1);
        step();
        checks++;
        if ({level, d_valid} !== {3'd0, 1'b0} || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL flush got lvl=%0d v=%b exp 0/0", level, d_valid);
        end
        set_in(1'b1, 16'h80, 32'h8080_0001, 1'b0, 1'b0);
        checks++;
        if (d_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_bypass got v=%b exp 0", d_valid);
        end
        step();
        set_in(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({d_valid, d_pc, level} !== {1'b1, 16'h80, 3'd1} || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL flush_repush got v=%b pc=%h lvl=%0d exp 1/0080/1",
                               d_valid, d_pc, level);
        end
    endtask

    task automatic test_double_flush();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 16'h500 + 16'(4*i), 32'h5555_0000 + 32'(i), 1'b0, 1'b1);
            step();
            checks++;
            if (level !== 3'd0 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL dflush_cyc%0d got lvl=%0d exp 0", i, level);
            end
        end
        set_in(1'b1, 16'h600, 32'h6666_6666, 1'b0, 1'b0);
        step();
        set_in(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({level, d_pc} !== {3'd1, 16'h600} || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL dflush_push got lvl=%0d pc=%h exp 1/0600", level, d_pc);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 16'($urandom), $urandom,
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (bad < 5) $display("FAIL random_cyc%0d got %h exp %h", i, obs_vec(), exp_vec());
                bad++;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_pop();
        test_streaming();
        test_flush();
        test_double_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
